// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream valid/ready channel feeding the boot loader
interface imem_boot_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a framed byte stream into imem words, checks XOR, releases the core
module imem_boot_loader #(
  parameter int         ADDR_W    = 10,
  parameter int         MAX_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_boot_loader_if.slave    stream,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_waddr,
  output logic [31:0]          imem_wdata,
  output logic                 core_run,
  output logic                 busy,
  output logic                 error,
  output logic [15:0]          words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
  localparam logic [16:0] MAX = 17'(MAX_WORDS);
  state_t      state, state_next;
  logic [15:0] len;
  logic [15:0] n;
  logic [23:0] word;
  logic [7:0]  chk;
  logic [1:0]  byte_cnt;
  logic        xfer;
  logic        last_word;
  assign stream.ready = !(state == DONE || state == ERROR);
  assign busy         = !(state == IDLE || state == DONE || state == ERROR);
  assign xfer         = stream.valid && stream.ready;
  assign n            = {stream.data, len[7:0]};
  assign last_word    = (words_loaded + 16'd1) == len;
  always_comb begin
    state_next = state;
    if (xfer)
      case (state)
        IDLE:    state_next = stream.data == SYNC_BYTE ? LEN_LO : IDLE;
        LEN_LO:  state_next = LEN_HI;
        LEN_HI:  state_next = {1'b0, n} > MAX ? ERROR : n == 16'd0 ? CHECK : DATA;
        DATA:    state_next = byte_cnt == 2'd3 && last_word ? CHECK : DATA;
        CHECK:   state_next = stream.data == chk ? DONE : ERROR;
        default: state_next = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      len          <= '0;
      word         <= '0;
      chk          <= '0;
      byte_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_run     <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state    <= state_next;
      imem_we  <= 1'b0;
      core_run <= state_next == DONE;
      error    <= state_next == ERROR;
      if (xfer && state == LEN_LO) len[7:0] <= stream.data;
      if (xfer && state == LEN_HI) len[15:8] <= stream.data;
      if (xfer && state == DATA) begin
        chk      <= chk ^ stream.data;
        byte_cnt <= byte_cnt + 2'd1;
        word     <= {stream.data, word[23:8]};
        // Fourth byte completes the word; first byte ends up in bits [7:0]
        if (byte_cnt == 2'd3) begin
          imem_we      <= 1'b1;
          imem_wdata   <= {stream.data, word};
          imem_waddr   <= words_loaded[ADDR_W-1:0];
          words_loaded <= words_loaded == 16'(MAX_WORDS) ? words_loaded : words_loaded + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frames with hand-computed words, checksum and status
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_run;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [7:0]  frame[11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  int          base;

  imem_boot_loader_if stream();

  imem_boot_loader dut (
    .clk(clk), .reset(reset), .stream(stream.slave), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_run(core_run), .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (imem_we) begin
      wa.push_back(int'(imem_waddr));
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    stream.data = 8'hEE;
    repeat (gap) begin @(posedge clk); #1; end
    stream.data  = b;
    stream.valid = 1'b1;
    @(posedge clk); #1;
    stream.valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input int gap_max);
    for (int i = 0; i < 11; i++) send(frame[i], $urandom_range(0, gap_max));
    send(c, $urandom_range(0, gap_max));
  endtask

  task automatic check_words(input string tag);
    check({tag, "_nwr"}, wa.size() - base, 2);
    check({tag, "_a0"}, wa[base], 0);
    check({tag, "_d0"}, wd[base], 32'h0000_0013);
    check({tag, "_a1"}, wa[base+1], 1);
    check({tag, "_d1"}, wd[base+1], 32'h0010_0093);
    check({tag, "_run"}, core_run, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, error, 1'b0);
    check({tag, "_wl"}, words_loaded, 16'd2);
    check({tag, "_rdy"}, stream.ready, 1'b0);
  endtask

  initial begin
    stream.data  = 8'hA5;
    stream.valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", stream.ready, 1'b1);
    check("rst_run", core_run, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_err", error, 1'b0);
    check("rst_wl", words_loaded, 16'd0);
    check("rst_busy", busy, 1'b0);
    stream.valid = 1'b0;
    reset = 1'b1;

    // payload XOR: 13^93^10 = 90
    base = wa.size();
    send_frame(8'h90, 0);
    check_words("b2b");
    check("b2b_gap", wc[base+1] - wc[base], 4);

    do_reset();
    base = wa.size();
    send_frame(8'h81, 0);
    check("bad_err", error, 1'b1);
    check("bad_run", core_run, 1'b0);
    check("bad_rdy", stream.ready, 1'b0);
    for (int i = 0; i < 11; i++) send(frame[i], 0);
    check("bad_sticky", error, 1'b1);
    check("bad_nwr", wa.size() - base, 2);
    check("bad_wl", words_loaded, 16'd2);

    do_reset();
    base = wa.size();
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    check("garb_busy", busy, 1'b0);
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    check("zero_busy", busy, 1'b1);
    check("zero_run0", core_run, 1'b0);
    send(8'h00, 0);
    check("zero_run", core_run, 1'b1);
    check("zero_nwr", wa.size() - base, 0);
    check("zero_err", error, 1'b0);

    do_reset();
    base = wa.size();
    send(8'hA5, 0); send(8'h01, 0); send(8'h04, 0);
    check("long_err", error, 1'b1);
    check("long_rdy", stream.ready, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h11, 0);
    check("long_nwr", wa.size() - base, 0);
    check("long_run", core_run, 1'b0);

    do_reset();
    base = wa.size();
    send_frame(8'h90, 3);
    check_words("tog");

    do_reset();
    base = wa.size();
    for (int i = 0; i < 9; i++) send(frame[i], $urandom_range(0, 2));
    check("mid_nwr", wa.size() - base, 1);
    check("mid_wl", words_loaded, 16'd1);
    do_reset();
    check("mid_busy", busy, 1'b0);
    check("mid_wl0", words_loaded, 16'd0);
    check("mid_rdy", stream.ready, 1'b1);
    check("mid_run", core_run, 1'b0);
    base = wa.size();
    send_frame(8'h90, 1);
    check_words("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
